// File: rtl/spi_flash_writer.sv
// SPI mode-0 page programmer for the boot flash: WREN, PP (addr + streamed payload),
// then RDSR polling until WIP clears or the poll budget runs out.
module spi_flash_writer #(
  parameter int CLK_DIV  = 2,
  parameter int CS_GAP   = 4,
  parameter int POLL_MAX = 65535
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] addr,
  input  logic [7:0]  wdata,
  input  logic        wvalid,
  output logic        wready,
  input  logic        wlast,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        flash_cs_n,
  output logic        flash_sck,
  output logic        flash_mosi,
  input  logic        flash_miso
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam int PW = $clog2(POLL_MAX + 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(CS_GAP - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);

  typedef enum logic [2:0] {IDLE, WREN, GAP1, PP_HDR, PP_DATA, GAP2, RDSR, FIN} state_t;

  state_t         state_q, state_d;
  logic           cs_n_q, cs_n_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic [1:0]     hdr_q, hdr_d;
  logic [8:0]     rem_q, rem_d;
  logic           last_q, last_d;
  logic           cmd_q, cmd_d;
  logic [PW-1:0]  poll_q, poll_d;
  logic           err_q, err_d;
  logic [23:0]    addr_q, addr_d;

  // byte engine
  logic           act_q, act_d;
  logic [DW-1:0]  div_q, div_d;
  logic           sck_q, sck_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     sh_q, sh_d;
  logic           miso_q, miso_d;
  logic           ld;
  logic [7:0]     ld_byte;
  logic           eng_fin;
  logic           wready_c;

  // Last clock of the last SCK-high half: a new byte may be loaded here back-to-back.
  assign eng_fin  = act_q && sck_q && (div_q == DIV_LAST) && (bit_q == 3'd7);
  assign wready_c = (state_q == PP_DATA) && !last_q && (!act_q || eng_fin);

  always_comb begin
    act_d  = act_q;
    div_d  = div_q;
    sck_d  = sck_q;
    bit_d  = bit_q;
    sh_d   = sh_q;
    miso_d = miso_q;
    if (act_q) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        if (!sck_q) begin
          sck_d  = 1'b1;
          miso_d = flash_miso;
        end else begin
          sck_d = 1'b0;
          if (bit_q == 3'd7) begin
            act_d = 1'b0;
            sh_d  = '0;
          end else begin
            bit_d = bit_q + 3'd1;
            sh_d  = {sh_q[6:0], 1'b0};
          end
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end
    if (ld) begin
      act_d = 1'b1;
      div_d = '0;
      sck_d = 1'b0;
      bit_d = '0;
      sh_d  = ld_byte;
    end
  end

  always_comb begin
    state_d = state_q;
    cs_n_d  = cs_n_q;
    gap_d   = gap_q;
    hdr_d   = hdr_q;
    rem_d   = rem_q;
    last_d  = last_q;
    cmd_d   = cmd_q;
    poll_d  = poll_q;
    err_d   = err_q;
    addr_d  = addr_q;
    ld      = 1'b0;
    ld_byte = 8'h00;
    case (state_q)
      IDLE: if (start) begin
        addr_d  = addr;
        rem_d   = 9'd256 - {1'b0, addr[7:0]};
        last_d  = 1'b0;
        err_d   = 1'b0;
        cs_n_d  = 1'b0;
        ld      = 1'b1;
        ld_byte = 8'h06;
        state_d = WREN;
      end
      WREN: if (eng_fin) begin
        cs_n_d  = 1'b1;
        gap_d   = '0;
        state_d = GAP1;
      end
      GAP1: begin
        if (gap_q == GAP_LAST) begin
          cs_n_d  = 1'b0;
          ld      = 1'b1;
          ld_byte = 8'h02;
          hdr_d   = '0;
          state_d = PP_HDR;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      PP_HDR: if (eng_fin) begin
        if (hdr_q == 2'd3) begin
          state_d = PP_DATA;
        end else begin
          ld      = 1'b1;
          ld_byte = (hdr_q == 2'd0) ? addr_q[23:16] :
                    (hdr_q == 2'd1) ? addr_q[15:8] : addr_q[7:0];
          hdr_d   = hdr_q + 2'd1;
        end
      end
      PP_DATA: begin
        if (wvalid && wready_c) begin
          ld      = 1'b1;
          ld_byte = wdata;
          rem_d   = rem_q - 9'd1;
          // stop at the page end so the flash never wraps to the page start
          if (wlast || rem_q == 9'd1) last_d = 1'b1;
        end else if (last_q && eng_fin) begin
          cs_n_d  = 1'b1;
          gap_d   = '0;
          state_d = GAP2;
        end
      end
      GAP2: begin
        if (gap_q == GAP_LAST) begin
          cs_n_d  = 1'b0;
          ld      = 1'b1;
          ld_byte = 8'h05;
          cmd_d   = 1'b1;
          poll_d  = '0;
          state_d = RDSR;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      RDSR: if (eng_fin) begin
        // miso_q holds the last sampled bit, i.e. status bit0 (WIP)
        if (cmd_q) begin
          cmd_d = 1'b0;
          ld    = 1'b1;
        end else if (!miso_q) begin
          cs_n_d  = 1'b1;
          state_d = FIN;
        end else if (poll_q == POLL_LAST) begin
          err_d   = 1'b1;
          cs_n_d  = 1'b1;
          state_d = FIN;
        end else begin
          poll_d = poll_q + 1'b1;
          ld     = 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cs_n_q  <= 1'b1;
      gap_q   <= '0;
      hdr_q   <= '0;
      rem_q   <= '0;
      last_q  <= 1'b0;
      cmd_q   <= 1'b0;
      poll_q  <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      act_q   <= 1'b0;
      div_q   <= '0;
      sck_q   <= 1'b0;
      bit_q   <= '0;
      sh_q    <= '0;
      miso_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cs_n_q  <= cs_n_d;
      gap_q   <= gap_d;
      hdr_q   <= hdr_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
      cmd_q   <= cmd_d;
      poll_q  <= poll_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      act_q   <= act_d;
      div_q   <= div_d;
      sck_q   <= sck_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      miso_q  <= miso_d;
    end
  end

  assign wready     = wready_c;
  assign busy       = (state_q != IDLE) && (state_q != FIN);
  assign done       = (state_q == FIN);
  assign error      = err_q;
  assign flash_cs_n = cs_n_q;
  assign flash_sck  = sck_q;
  assign flash_mosi = sh_q[7];

endmodule

// File: tb/tb_spi_flash_writer.sv
// Bench for spi_flash_writer: a small SPI flash model logs MOSI bytes per CS window
// and answers RDSR with a programmable number of WIP=1 status bytes.
module tb_spi_flash_writer;
  localparam int CLK_DIV = 2, CS_GAP = 4, POLL_MAX = 8;

  logic clock = 1'b0, reset = 1'b1, start = 1'b0, wvalid = 1'b0, wlast = 1'b0;
  logic [23:0] addr = '0;
  logic [7:0] wdata = '0;
  logic wready, busy, done, error, flash_cs_n, flash_sck, flash_mosi;
  logic miso_r = 1'b0;

  always #5 clock = ~clock;

  spi_flash_writer #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP), .POLL_MAX(POLL_MAX)) dut (
    .clock(clock), .reset(reset), .start(start), .addr(addr), .wdata(wdata),
    .wvalid(wvalid), .wready(wready), .wlast(wlast), .busy(busy), .done(done),
    .error(error), .flash_cs_n(flash_cs_n), .flash_sck(flash_sck),
    .flash_mosi(flash_mosi), .flash_miso(miso_r));

  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // flash model / monitor, sampled on the falling system clock
  int epoch = 0, seen = 0, wip_n = 0;
  logic [7:0] bytes_q[$];
  int winof_q[$], lens_q[$], his_q[$], gaps_q[$];
  int win = 0, done_cnt = 0, rises = 0, cur_len = 0, cur_hi = 0, gapc = 0, bitc = 0, bidx = 0;
  logic [7:0] sh = '0, first = '0, stat = '0;
  bit in_win = 0, sck_prev = 0, err_at_done = 0, busy_at_done = 0;

  always @(negedge clock) begin
    if (epoch != seen) begin
      seen = epoch; bytes_q.delete(); winof_q.delete(); lens_q.delete(); his_q.delete();
      gaps_q.delete(); win = 0; done_cnt = 0; rises = 0; gapc = 0; in_win = 0; miso_r = 1'b0;
    end
    if (done) begin done_cnt++; err_at_done = error; busy_at_done = busy; end
    if (!flash_cs_n) begin
      if (!in_win) begin
        if (win > 0) gaps_q.push_back(gapc);
        in_win = 1; win++; bitc = 0; bidx = 0; cur_len = 0; cur_hi = 0; first = '0; miso_r = 1'b0;
      end
      cur_len++;
      if (flash_sck) cur_hi++;
      if (flash_sck && !sck_prev) begin
        rises++; sh = {sh[6:0], flash_mosi}; bitc++;
        if (bitc == 8) begin
          bitc = 0; bytes_q.push_back(sh); winof_q.push_back(win);
          if (bidx == 0) first = sh;
          bidx++;
        end
      end
      if (!flash_sck && sck_prev) begin
        stat = (bidx >= 1 && first == 8'h05) ? ((bidx - 1 < wip_n) ? 8'h03 : 8'h02) : 8'h00;
        miso_r = stat[7 - bitc];
      end
    end else begin
      if (in_win) begin
        in_win = 0; lens_q.push_back(cur_len); his_q.push_back(cur_hi); gapc = 0;
      end
      gapc++;
    end
    sck_prev = flash_sck;
  end

  typedef struct {
    logic [23:0]     addr;
    logic [0:4][7:0] data;
    int n_offer, last_at, wip_n, exp_acc, exp_stat;
    bit exp_err;
  } vec_t;

  vec_t vecs[6];
  bit prev_err = 0;

  function automatic logic [7:0] byte_of(input vec_t v, input int i);
    if (i < 5) return v.data[i];
    return 8'(i * 13 + 1);
  endfunction

  task automatic send(input logic [7:0] d, input bit last, output bit ok);
    wdata = d; wlast = last; wvalid = 1'b1; ok = 0;
    for (int k = 0; k < 400 && !ok; k++) begin
      if (wready) ok = 1;
      @(negedge clock);
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 30000 && done_cnt == 0; k++) @(negedge clock);
  endtask

  task automatic check_win(input string nm, input int w, input logic [7:0] e[$]);
    logic [7:0] g[$];
    int mism = 0;
    foreach (bytes_q[k]) if (winof_q[k] == w) g.push_back(bytes_q[k]);
    chk({nm, ".len"}, g.size(), e.size());
    foreach (e[k]) if (k >= g.size() || g[k] !== e[k]) mism++;
    chk({nm, ".bytes"}, mism, 0);
  endtask

  task automatic run(input vec_t v, input bit poke, input string tag);
    int acc = 0;
    bit ok = 1;
    logic [7:0] e[$];
    epoch++; wip_n = v.wip_n;
    repeat (2) @(negedge clock);
    chk({tag, ".err_held"}, error, prev_err);
    addr = v.addr; start = 1'b1; @(negedge clock); start = 1'b0; addr = '0;
    chk({tag, ".busy"}, busy, 1);
    chk({tag, ".err_clr"}, error, 0);
    fork
      for (int i = 0; i < v.n_offer && ok; i++) begin
        send(byte_of(v, i), (i + 1 == v.last_at), ok);
        if (ok) acc++;
      end
      wait_done();
      if (poke) begin
        for (int k = 0; k < 30000 && win < 3; k++) @(negedge clock);
        repeat (6) @(negedge clock);
        addr = 24'h777777; start = 1'b1; @(negedge clock); start = 1'b0; addr = '0;
      end
    join
    repeat (50) @(negedge clock);
    chk({tag, ".done_cnt"}, done_cnt, 1);
    chk({tag, ".accepted"}, acc, v.exp_acc);
    chk({tag, ".error"}, err_at_done, v.exp_err);
    chk({tag, ".busy_at_done"}, busy_at_done, 0);
    chk({tag, ".windows"}, win, 3);
    chk({tag, ".win1_len"}, lens_q.size() > 0 ? lens_q[0] : -1, 16 * CLK_DIV);
    chk({tag, ".win1_sck_hi"}, his_q.size() > 0 ? his_q[0] : -1, 8 * CLK_DIV);
    chk({tag, ".gap1"}, gaps_q.size() > 0 ? gaps_q[0] : -1, CS_GAP);
    chk({tag, ".gap2"}, gaps_q.size() > 1 ? gaps_q[1] : -1, CS_GAP);
    e = {8'h06};
    check_win({tag, ".wren"}, 1, e);
    e = {8'h02, v.addr[23:16], v.addr[15:8], v.addr[7:0]};
    for (int i = 0; i < v.exp_acc; i++) e.push_back(byte_of(v, i));
    check_win({tag, ".pp"}, 2, e);
    e = {8'h05};
    for (int i = 0; i < v.exp_stat; i++) e.push_back(8'h00);
    check_win({tag, ".rdsr"}, 3, e);
    prev_err = v.exp_err;
  endtask

  initial begin
    vec_t pv;
    bit ok;
    int r0, hb;
    logic [7:0] e[$];
    vecs[0] = '{24'h012300, {8'hA5, 8'h5A, 8'h00, 8'hFF, 8'h00}, 4, 4, 3, 4, 4, 0};
    vecs[1] = '{24'h0000FE, {8'h11, 8'h22, 8'h33, 8'h44, 8'h55}, 5, 5, 0, 2, 1, 0};
    vecs[2] = '{24'hABCDFF, {8'hC3, 8'h3C, 8'h99, 8'h00, 8'h00}, 3, 3, 1, 1, 2, 0};
    vecs[3] = '{24'h123456, {8'h7E, 8'h81, 8'h00, 8'h00, 8'h00}, 2, 2, 1000, 2, 8, 1};
    vecs[4] = '{24'h000000, {8'h01, 8'h02, 8'h04, 8'h08, 8'h10}, 258, 0, 2, 256, 3, 0};
    vecs[5] = '{24'h000040, {8'hDE, 8'hAD, 8'hBE, 8'h00, 8'h00}, 3, 3, 0, 3, 1, 0};

    repeat (3) @(negedge clock);
    chk("rst.cs_n", flash_cs_n, 1);
    chk("rst.sck", flash_sck, 0);
    chk("rst.mosi", flash_mosi, 0);
    chk("rst.wready", wready, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.error", error, 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    foreach (vecs[i]) run(vecs[i], 0, $sformatf("vec%0d", i));

    pv = '{24'h00ABC0, {8'h5C, 8'hC5, 8'h00, 8'h00, 8'h00}, 2, 2, 3, 2, 4, 0};
    run(pv, 1, "start_in_rdsr");

    // wvalid held low mid-page: CS stays low, SCK parked low, no extra edges
    epoch++; wip_n = 0;
    repeat (2) @(negedge clock);
    addr = 24'h000010; start = 1'b1; @(negedge clock); start = 1'b0;
    send(8'hB0, 0, ok);
    chk("hold.first_ok", ok, 1);
    repeat (40) @(negedge clock);
    r0 = rises; hb = 0;
    repeat (60) begin
      @(negedge clock);
      if (flash_cs_n !== 1'b0 || flash_sck !== 1'b0) hb++;
    end
    chk("hold.pins", hb, 0);
    chk("hold.sck_edges", rises, r0);
    send(8'hB1, 0, ok);
    send(8'hB2, 1, ok);
    wait_done();
    repeat (5) @(negedge clock);
    chk("hold.done_cnt", done_cnt, 1);
    chk("hold.error", err_at_done, 0);
    e = {8'h02, 8'h00, 8'h00, 8'h10, 8'hB0, 8'hB1, 8'hB2};
    check_win("hold.pp", 2, e);

    // async reset during the second data byte
    epoch++; wip_n = 0;
    repeat (2) @(negedge clock);
    addr = 24'h000100; start = 1'b1; @(negedge clock); start = 1'b0;
    send(8'hC1, 0, ok);
    send(8'hC2, 0, ok);
    chk("arst.second_ok", ok, 1);
    repeat (10) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("arst.cs_n", flash_cs_n, 1);
    chk("arst.sck", flash_sck, 0);
    chk("arst.busy", busy, 0);
    chk("arst.wready", wready, 0);
    chk("arst.mosi", flash_mosi, 0);
    @(negedge clock); reset = 1'b0;
    repeat (3) @(negedge clock);
    prev_err = 0;
    run(vecs[0], 0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_flash_writer.md
Name: spi_flash_writer

Overview:
- SPI-mode-0 controller that programs one page of the boot SPI flash.
- It is the write-side counterpart of the boot loader's flash read path.
- Sequence: Write Enable (0x06), then Page Program (0x02) with a 24-bit address and a streamed data payload, then Read Status (0x05) polling until WIP clears.
- Sits beside the boot block on the flash_* pins; the boot block and this block never drive the pins at the same time (muxing is external).

Parameters:
- CLK_DIV, 2: clock cycles per SCK half-period; one SCK period = 2*CLK_DIV clocks.
- CS_GAP, 4: clocks flash_cs_n is held high between commands.
- POLL_MAX, 65535: maximum status bytes read before timeout.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; latches addr. Ignored while busy.
- addr  in  24  flash byte address of the first data byte.
- wdata  in  8  payload byte.
- wvalid  in  1  wdata valid.
- wready  out  1  block can take a byte; transfer happens when wvalid&&wready.
- wlast  in  1  qualifies the final payload byte.
- busy  out  1  high from the cycle after an accepted start until the cycle done pulses.
- done  out  1  one-cycle completion pulse.
- error  out  1  status-poll timeout; valid with done, held until the next accepted start.
- flash_cs_n  out  1  chip select, active low.
- flash_sck  out  1  SPI clock, idles low.
- flash_mosi  out  1  controller to flash, MSB first.
- flash_miso  in  1  flash to controller.

Behaviour:
- Reset values (asynchronous, immediate, including mid-transfer): flash_cs_n=1, flash_sck=0, flash_mosi=0, wready=0, busy=0, done=0, error=0, FSM=IDLE. A partially programmed page is acceptable.
- Byte engine:
  - 8 bits, MSB first.
  - MOSI is set while SCK is low; SCK rises after CLK_DIV clocks; MISO is sampled on the rising edge; SCK falls after a further CLK_DIV clocks.
  - One byte = 16*CLK_DIV clocks.
  - SCK is low at every byte boundary.
- FSM states: IDLE -> WREN -> GAP1 -> PP_HDR -> PP_DATA -> GAP2 -> RDSR -> FIN -> IDLE.
- IDLE:
  - start latches addr and sets remaining = 256 - addr[7:0] (range 1..256).
  - Next cycle: busy=1, flash_cs_n=0, FSM=WREN. error clears at this point.
- WREN: sends 0x06, then flash_cs_n=1 for CS_GAP clocks (GAP1).
- PP_HDR: flash_cs_n=0; sends 0x02, addr[23:16], addr[15:8], addr[7:0].
- PP_DATA:
  - wready=1 only when the engine is at a byte boundary and waiting for data.
  - On handshake: wready drops the next cycle and the byte shifts out; remaining decrements.
  - If wvalid is low, hold with flash_cs_n=0 and flash_sck=0 indefinitely.
  - The page ends after a byte accepted with wlast=1, or after the byte that makes remaining=0 (page-boundary wrap prevention; wlast is ignored from then on and wready stays 0).
  - After the final byte finishes shifting, flash_cs_n=1 for CS_GAP clocks (GAP2).
- RDSR:
  - flash_cs_n=0; sends 0x05, then reads status bytes back-to-back with mosi=0.
  - After each byte: if bit0==0, go to FIN. Otherwise increment the poll count; when the count reaches POLL_MAX, set error=1 and go to FIN.
- FIN: flash_cs_n=1, done=1 for one cycle, busy=0 in the same cycle, then IDLE.
- start asserted while busy: ignored, no effect on the transfer.
- addr[7:0]=0xFF: exactly one data byte is accepted.
- addr[7:0]=0x00 with no wlast: 256 bytes are accepted.

Test Plan:
- CLK_DIV=2, start with addr=0x012300, 4 bytes {A5,5A,00,FF}, wlast on the 4th, flash model reports WIP=1 for 3 status reads -> MOSI shows 06 | 02 01 23 00 A5 5A 00 FF | 05; 4 status bytes read; 3 CS low-windows; done pulse with error=0; each byte spans 32 clocks.
- addr=0x0000FE, 5 bytes offered, wlast on the 5th -> only 2 bytes accepted; wready stays 0 afterwards; CS rises after the 2nd byte.
- wvalid deasserted for 100 clocks mid-page -> flash_cs_n stays 0, flash_sck stays 0, no extra SCK edges; transfer resumes correctly.
- POLL_MAX=8, flash model holds WIP=1 -> exactly 8 status bytes read after 0x05; done=1 with error=1; error stays 1 until the next start, then clears.
- Async reset asserted during PP_DATA byte 2 -> same cycle flash_cs_n=1, flash_sck=0, busy=0, wready=0; after release, a new start runs a full sequence normally.
- start pulsed during RDSR -> ignored: exactly one done pulse, addr not re-latched.
